// File: rtl/ula_ctrl.sv
// ula_ctrl: issue/capture stage around the combinational ULA (valid/ready in, valid/ready out).
// Define ULA_CTRL_BCD_EN to add out_bcd and a double-dabble CONV state between EXEC and DONE.
module ula_ctrl #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned OPC_W  = 4,
  parameter int unsigned RES_W  = 8,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OPC_W-1:0]  in_opcode,
  input  logic [DATA_W-1:0] in_op1,
  input  logic [DATA_W-1:0] in_op2,
  output logic [OPC_W-1:0]  ula_opcode,
  output logic [DATA_W-1:0] ula_operando1,
  output logic [DATA_W-1:0] ula_operando2,
  input  logic [RES_W-1:0]  ula_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RES_W-1:0]  out_result,
  output logic              out_div_zero,
  output logic              out_illegal,
  output logic [CNT_W-1:0]  op_count,
`ifdef ULA_CTRL_BCD_EN
  output logic [11:0]       out_bcd,
`endif
  output logic              busy
);

  // Opcode encodings, matching the ULA_* macros of constants.vh
  localparam logic [OPC_W-1:0] ULA_ADD  = OPC_W'(0);
  localparam logic [OPC_W-1:0] ULA_SUB  = OPC_W'(1);
  localparam logic [OPC_W-1:0] ULA_MULT = OPC_W'(2);
  localparam logic [OPC_W-1:0] ULA_DIV  = OPC_W'(3);
  localparam logic [OPC_W-1:0] ULA_AND  = OPC_W'(4);
  localparam logic [OPC_W-1:0] ULA_OR   = OPC_W'(5);
  localparam logic [OPC_W-1:0] ULA_XOR  = OPC_W'(6);
  localparam logic [OPC_W-1:0] ULA_NOT  = OPC_W'(7);

`ifdef ULA_CTRL_BCD_EN
  localparam int unsigned BCD_W = 12;
  localparam int unsigned SH_W  = BCD_W + RES_W;
  localparam int unsigned BIT_W = $clog2(RES_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2,
    CONV = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;
`endif

  state_t              state_q, state_d;
  logic [OPC_W-1:0]    opc_d;
  logic [DATA_W-1:0]   op1_d, op2_d;
  logic [RES_W-1:0]    res_d, exec_res;
  logic                dz_d, il_d, exec_dz, exec_il;
  logic [CNT_W-1:0]    cnt_d;

`ifdef ULA_CTRL_BCD_EN
  logic [SH_W-1:0]     sh_q, sh_d, sh_step;
  logic [BIT_W-1:0]    bitc_q, bitc_d;
  logic [BCD_W-1:0]    bcd_d;

  // One double-dabble iteration: add 3 to any digit >= 5, then shift left
  function automatic logic [SH_W-1:0] dd_step(input logic [SH_W-1:0] s);
    logic [SH_W-1:0] t;
    t = s;
    for (int d = 0; d < 3; d++) begin
      if (t[RES_W + 4*d +: 4] >= 4'd5)
        t[RES_W + 4*d +: 4] = t[RES_W + 4*d +: 4] + 4'd3;
    end
    return {t[SH_W-2:0], 1'b0};
  endfunction
`endif

  function automatic logic opc_legal(input logic [OPC_W-1:0] op);
    case (op)
      ULA_ADD, ULA_SUB, ULA_MULT, ULA_DIV,
      ULA_AND, ULA_OR, ULA_XOR, ULA_NOT: return 1'b1;
      default:                           return 1'b0;
    endcase
  endfunction

  // Next-state and next-register values
  always_comb begin
    state_d  = state_q;
    opc_d    = ula_opcode;
    op1_d    = ula_operando1;
    op2_d    = ula_operando2;
    res_d    = out_result;
    dz_d     = out_div_zero;
    il_d     = out_illegal;
    cnt_d    = op_count;
    exec_res = ula_result;
    exec_dz  = 1'b0;
    exec_il  = 1'b0;
`ifdef ULA_CTRL_BCD_EN
    sh_d     = sh_q;
    bitc_d   = bitc_q;
    bcd_d    = out_bcd;
    sh_step  = dd_step(sh_q);
`endif

    // Special cases override whatever the ULA produced
    if (!opc_legal(ula_opcode)) begin
      exec_res = '0;
      exec_il  = 1'b1;
    end else if (ula_opcode == ULA_DIV && ula_operando2 == '0) begin
      exec_res = '1;
      exec_dz  = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          opc_d   = in_opcode;
          op1_d   = in_op1;
          op2_d   = in_op2;
          state_d = EXEC;
        end
      end
      EXEC: begin
        res_d = exec_res;
        dz_d  = exec_dz;
        il_d  = exec_il;
`ifdef ULA_CTRL_BCD_EN
        sh_d    = {BCD_W'(0), exec_res};
        bitc_d  = '0;
        state_d = CONV;
`else
        state_d = DONE;
`endif
      end
`ifdef ULA_CTRL_BCD_EN
      CONV: begin
        sh_d   = sh_step;
        bitc_d = bitc_q + BIT_W'(1);
        if (bitc_q == BIT_W'(RES_W - 1)) begin
          bcd_d   = sh_step[SH_W-1 -: BCD_W];
          state_d = DONE;
        end
      end
`endif
      DONE: begin
        if (out_valid && out_ready) begin
          cnt_d   = op_count + CNT_W'(1);
          dz_d    = 1'b0;
          il_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; handshake outputs follow the next state
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      in_ready      <= 1'b0;
      busy          <= 1'b0;
      out_valid     <= 1'b0;
      ula_opcode    <= '0;
      ula_operando1 <= '0;
      ula_operando2 <= '0;
      out_result    <= '0;
      out_div_zero  <= 1'b0;
      out_illegal   <= 1'b0;
      op_count      <= '0;
`ifdef ULA_CTRL_BCD_EN
      sh_q          <= '0;
      bitc_q        <= '0;
      out_bcd       <= '0;
`endif
    end else begin
      state_q       <= state_d;
      in_ready      <= (state_d == IDLE);
      busy          <= (state_d != IDLE);
      out_valid     <= (state_d == DONE);
      ula_opcode    <= opc_d;
      ula_operando1 <= op1_d;
      ula_operando2 <= op2_d;
      out_result    <= res_d;
      out_div_zero  <= dz_d;
      out_illegal   <= il_d;
      op_count      <= cnt_d;
`ifdef ULA_CTRL_BCD_EN
      sh_q          <= sh_d;
      bitc_q        <= bitc_d;
      out_bcd       <= bcd_d;
`endif
    end
  end

endmodule

// File: tb/tb_ula_ctrl.sv
// Directed + random bench for ula_ctrl with a behavioural ULA and an expected-result queue.
// Build with ULA_CTRL_BCD_EN defined to exercise out_bcd and the longer latency.
module tb_ula_ctrl;

  typedef struct packed {
    logic [7:0]  res;
    logic        dz;
    logic        il;
    logic [11:0] bcd;
  } exp_t;

`ifdef ULA_CTRL_BCD_EN
  localparam int LAT = 9;
`else
  localparam int LAT = 1;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b1;
  logic       in_ready;
  logic [3:0] in_opcode = '0;
  logic [3:0] in_op1 = '0;
  logic [3:0] in_op2 = '0;
  logic [3:0] ula_opcode, ula_operando1, ula_operando2;
  logic [7:0] ula_result;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_result;
  logic       out_div_zero, out_illegal;
  logic [7:0] op_count;
  logic       busy;
`ifdef ULA_CTRL_BCD_EN
  logic [11:0] out_bcd;
`endif

  int         n_assert = 0;
  int         n_fail   = 0;
  logic [7:0] exp_cnt  = '0;
  exp_t       sb[$];

  ula_ctrl dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_op1(in_op1), .in_op2(in_op2),
    .ula_opcode(ula_opcode), .ula_operando1(ula_operando1), .ula_operando2(ula_operando2),
    .ula_result(ula_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_div_zero(out_div_zero), .out_illegal(out_illegal),
    .op_count(op_count),
`ifdef ULA_CTRL_BCD_EN
    .out_bcd(out_bcd),
`endif
    .busy(busy)
  );

  always #5 clock = ~clock;

  // Behavioural ULA; div-by-zero and illegal codes return junk the stage must override
  always_comb begin
    case (ula_opcode)
      4'd0: ula_result = 8'(ula_operando1) + 8'(ula_operando2);
      4'd1: ula_result = 8'(ula_operando1) - 8'(ula_operando2);
      4'd2: ula_result = 8'(ula_operando1) * 8'(ula_operando2);
      4'd3: ula_result = (ula_operando2 == 4'd0) ? 8'h00 : 8'(ula_operando1 / ula_operando2);
      4'd4: ula_result = 8'(ula_operando1 & ula_operando2);
      4'd5: ula_result = 8'(ula_operando1 | ula_operando2);
      4'd6: ula_result = 8'(ula_operando1 ^ ula_operando2);
      4'd7: ula_result = 8'(~ula_operando1);
      default: ula_result = 8'h5A;
    endcase
  end

  function automatic exp_t mk(input logic [7:0] r, input logic dz, input logic il);
    exp_t e;
    e.res = r;
    e.dz  = dz;
    e.il  = il;
    e.bcd = (12'(r / 8'd100) << 8) | (12'((r / 8'd10) % 8'd10) << 4) | 12'(r % 8'd10);
    return e;
  endfunction

  function automatic exp_t model(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
    case (op)
      4'd0: return mk(8'(a) + 8'(b), 1'b0, 1'b0);
      4'd1: return mk(8'(a) - 8'(b), 1'b0, 1'b0);
      4'd2: return mk(8'(a) * 8'(b), 1'b0, 1'b0);
      4'd3: return (b == 4'd0) ? mk(8'hFF, 1'b1, 1'b0) : mk(8'(a / b), 1'b0, 1'b0);
      4'd4: return mk(8'(a & b), 1'b0, 1'b0);
      4'd5: return mk(8'(a | b), 1'b0, 1'b0);
      4'd6: return mk(8'(a ^ b), 1'b0, 1'b0);
      4'd7: return mk(8'(~a), 1'b0, 1'b0);
      default: return mk(8'h00, 1'b0, 1'b1);
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                       input exp_t e);
    int t = 0;
    while (in_ready !== 1'b1 && t < 40) begin step(); t++; end
    chk("in_ready_timeout", in_ready, 1);
    in_valid = 1'b1; in_opcode = op; in_op1 = a; in_op2 = b;
    sb.push_back(e);
    step();
    in_valid = 1'b0;
    chk("in_ready_after_accept", in_ready, 0);
    chk("busy_after_accept", busy, 1);
  endtask

  // Wait for out_valid, compare against the queue head, then complete the handshake
  task automatic collect(input int exp_lat);
    int   t = 0;
    exp_t e;
    while (out_valid !== 1'b1 && t < 40) begin step(); t++; end
    chk("out_valid_timeout", out_valid, 1);
    if (exp_lat >= 0) chk("latency", t, exp_lat);
    if (sb.size() == 0) chk("scoreboard_nonempty", sb.size(), 1);
    else begin
      e = sb.pop_front();
      chk("out_result", out_result, e.res);
      chk("out_div_zero", out_div_zero, e.dz);
      chk("out_illegal", out_illegal, e.il);
`ifdef ULA_CTRL_BCD_EN
      chk("out_bcd", out_bcd, e.bcd);
`endif
    end
    out_ready = 1'b1;
    step();
    exp_cnt = exp_cnt + 8'd1;
    chk("op_count", op_count, exp_cnt);
    chk("out_valid_drop", out_valid, 0);
    chk("in_ready_return", in_ready, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog op_count=%0d expected_done=1", op_count);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] rop, ra, rb;

    // Reset held with in_valid asserted
    repeat (3) step();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_op_count", op_count, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0; in_valid = 1'b0;
    step();
    chk("post_rst_in_ready", in_ready, 1);

    // ADD 9,7
    issue(4'd0, 4'd9, 4'd7, '{res: 8'h10, dz: 1'b0, il: 1'b0, bcd: 12'h016});
    collect(LAT);

    // MULT 15,15 then SUB 3,5
    issue(4'd2, 4'd15, 4'd15, '{res: 8'hE1, dz: 1'b0, il: 1'b0, bcd: 12'h225});
    collect(LAT);
    issue(4'd1, 4'd3, 4'd5, '{res: 8'hFE, dz: 1'b0, il: 1'b0, bcd: 12'h254});
    collect(LAT);
    chk("op_count_two_plus_one", op_count, 3);

    // Divide by zero, then a normal divide
    issue(4'd3, 4'd9, 4'd0, '{res: 8'hFF, dz: 1'b1, il: 1'b0, bcd: 12'h255});
    collect(LAT);
    issue(4'd3, 4'd9, 4'd2, '{res: 8'h04, dz: 1'b0, il: 1'b0, bcd: 12'h004});
    collect(LAT);
    chk("hold_ula_opcode", ula_opcode, 3);
    chk("hold_ula_op1", ula_operando1, 9);
    chk("hold_ula_op2", ula_operando2, 2);

    // Illegal opcode
    issue(4'hC, 4'd1, 4'd1, '{res: 8'h00, dz: 1'b0, il: 1'b1, bcd: 12'h000});
    collect(LAT);

    // Downstream stall for 5 cycles in DONE
    out_ready = 1'b0;
    issue(4'd0, 4'd2, 4'd3, '{res: 8'h05, dz: 1'b0, il: 1'b0, bcd: 12'h005});
    repeat (LAT) step();
    for (int i = 0; i < 5; i++) begin
      chk("stall_out_valid", out_valid, 1);
      chk("stall_out_result", out_result, 8'h05);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_op_count", op_count, exp_cnt);
      step();
    end
    out_ready = 1'b1;
    collect(-1);

    // Reset while in EXEC drops the pending operation
    issue(4'd0, 4'd1, 4'd1, mk(8'h02, 1'b0, 1'b0));
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_op_count", op_count, 0);
    sb.delete();
    exp_cnt = '0;
    step();
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid_idle", out_valid, 0);

    // 256 random operations: op_count wraps back to 0
    for (int i = 0; i < 256; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = 4'($urandom_range(0, 15));
      rb  = 4'($urandom_range(0, 15));
      issue(rop, ra, rb, model(rop, ra, rb));
      collect(LAT);
    end
    chk("op_count_wrap", op_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
